// File: rtl/pulse_sequencer_if.sv
// Descriptor, waveform-memory and DAC-sample signals of the pulse sequencer.
// The slave modport is the sequencer's view; master is the surrounding core/bench.
interface pulse_sequencer_if #(
    parameter int DELAY_W  = 32,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
);
    logic                desc_valid;
    logic                desc_ready;
    logic [DELAY_W-1:0]  desc_delay;
    logic [ADDR_W-1:0]   desc_addr;
    logic                abort;
    logic                pmem_rd_en;
    logic [ADDR_W-1:0]   pmem_addr;
    logic [SAMPLE_W:0]   pmem_rdata;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_sample;
    logic                out_last;
    logic                busy;
    logic                len_err;

    modport slave (
        input  desc_valid, desc_delay, desc_addr, abort, pmem_rdata,
        output desc_ready, pmem_rd_en, pmem_addr, out_valid, out_sample, out_last, busy, len_err
    );

    modport master (
        output desc_valid, desc_delay, desc_addr, abort, pmem_rdata,
        input  desc_ready, pmem_rd_en, pmem_addr, out_valid, out_sample, out_last, busy, len_err
    );
endinterface

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: accepts {delay, addr} descriptors, waits, then streams {last, sample}
// words from a synchronous waveform RAM to the DAC port until the end marker or MAX_LEN.
module pulse_sequencer #(
    parameter int DELAY_W  = 32,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16,
    parameter int MAX_LEN  = 256
) (
    input  logic             clk,
    input  logic             reset,
    pulse_sequencer_if.slave bus
);
    localparam int SCNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_PLAY} state_t;

    state_t              r_state, w_state_nxt;
    logic [DELAY_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [SCNT_W-1:0]   r_scnt, w_scnt_nxt;
    logic                r_len_err, w_len_err_nxt;
    logic                w_marker;
    logic                w_term;

    assign w_marker = bus.pmem_rdata[SAMPLE_W];
    assign w_term   = w_marker || (r_scnt == SCNT_W'(MAX_LEN - 1));

    assign bus.pmem_addr = r_addr;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.len_err   = r_len_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_scnt    <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_scnt    <= w_scnt_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_scnt_nxt     = r_scnt;
        w_len_err_nxt  = r_len_err;
        bus.desc_ready = 1'b0;
        bus.pmem_rd_en = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_sample = '0;
        bus.out_last   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort is deliberately ignored here so it cannot block a handshake
                bus.desc_ready = 1'b1;
                if (bus.desc_valid) begin
                    w_addr_nxt = bus.desc_addr;
                    if (bus.desc_delay != '0) begin
                        w_cnt_nxt   = bus.desc_delay;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_WAIT: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - DELAY_W'(1);
                    if (r_cnt == DELAY_W'(1)) begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    bus.pmem_rd_en = 1'b1;
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                    w_scnt_nxt     = '0;
                    w_state_nxt    = S_PLAY;
                end
            end

            S_PLAY: begin
                // The word read last cycle is always live; the next read is overlapped with it.
                bus.out_valid  = 1'b1;
                bus.out_sample = bus.pmem_rdata[SAMPLE_W-1:0];
                w_scnt_nxt     = r_scnt + SCNT_W'(1);
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_term) begin
                    bus.out_last = 1'b1;
                    w_state_nxt  = S_IDLE;
                    if (!w_marker) begin
                        w_len_err_nxt = 1'b1;
                    end
                end else begin
                    bus.pmem_rd_en = 1'b1;
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed and randomized descriptors checked cycle by cycle
// against a pulse-level model that derives timing and samples from the waveform memory.
module tb_pulse_sequencer;
    localparam int DELAY_W  = 32;
    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 16;
    localparam int MAX_LEN  = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic exp_len_err = 1'b0;
    logic [SAMPLE_W:0] mem [DEPTH];

    pulse_sequencer_if #(.DELAY_W(DELAY_W), .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    pulse_sequencer #(
        .DELAY_W(DELAY_W), .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // synchronous waveform RAM: data one cycle after the strobe
    always @(posedge clk) begin
        if (bus.pmem_rd_en) bus.pmem_rdata <= mem[bus.pmem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int d, input int a, input logic ab);
        bus.desc_valid = v;
        bus.desc_delay = DELAY_W'(d);
        bus.desc_addr  = ADDR_W'(a);
        bus.abort      = ab;
    endtask

    // Pulse length is the first marker within MAX_LEN words, else MAX_LEN with an error.
    task automatic pulse_model(input int a, output int n, output bit err);
        n   = MAX_LEN;
        err = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (mem[(a + i) % DEPTH][SAMPLE_W]) begin
                n   = i + 1;
                err = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_pulse(input int d, input int a, input int abort_at);
        int n;
        bit err;
        int end_cyc;
        logic [SAMPLE_W:0] w;
        logic exp_valid, exp_last, exp_rd;
        logic [SAMPLE_W-1:0] exp_sample;
        pulse_model(a, n, err);
        end_cyc = (abort_at > 0) ? abort_at : d + 1 + n;

        @(negedge clk);
        drive(1'b1, d, a, 1'(($urandom % 2)));
        #1;
        check("hs_ready", 32'(bus.desc_ready), 32'd1);
        check("hs_busy", 32'(bus.busy), 32'd0);

        for (int c = 1; c <= end_cyc; c++) begin
            @(negedge clk);
            drive(1'($urandom % 2), int'($urandom_range(0, 9)), int'($urandom_range(0, DEPTH - 1)),
                  1'(c == abort_at));
            #1;
            exp_valid  = (c >= d + 2) && (c <= d + 1 + n);
            w          = mem[(a + c - d - 2 + DEPTH) % DEPTH];
            exp_sample = exp_valid ? w[SAMPLE_W-1:0] : '0;
            exp_last   = exp_valid && (c == d + 1 + n) && (c != abort_at);
            exp_rd     = (c >= d + 1) && (c <= d + n) && (c != abort_at);
            check("busy", 32'(bus.busy), 32'd1);
            check("ready_busy", 32'(bus.desc_ready), 32'd0);
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("out_sample", 32'(bus.out_sample), 32'(exp_sample));
            check("out_last", 32'(bus.out_last), 32'(exp_last));
            check("rd_en", 32'(bus.pmem_rd_en), 32'(exp_rd));
            if (exp_rd) check("rd_addr", 32'(bus.pmem_addr), 32'((a + c - d - 1) % DEPTH));
            check("len_err", 32'(bus.len_err), 32'(exp_len_err));
        end

        if (abort_at == 0 && err) exp_len_err = 1'b1;

        @(negedge clk);
        drive(1'b0, 0, 0, 1'b0);
        #1;
        check("end_ready", 32'(bus.desc_ready), 32'd1);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_valid", 32'(bus.out_valid), 32'd0);
        check("end_last", 32'(bus.out_last), 32'd0);
        check("end_len_err", 32'(bus.len_err), 32'(exp_len_err));
    endtask

    initial begin
        int d, a, len;
        drive(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) mem[i] = {1'b1, SAMPLE_W'(i * 7 + 3)};

        @(negedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sample", 32'(bus.out_sample), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_rd_en", 32'(bus.pmem_rd_en), 32'd0);
        check("rst_len_err", 32'(bus.len_err), 32'd0);
        check("rst_addr", 32'(bus.pmem_addr), 32'd0);
        reset = 1'b0;

        // three-word pulse, no delay
        mem[5] = {1'b0, 16'h0011};
        mem[6] = {1'b0, 16'h0022};
        mem[7] = {1'b1, 16'h0033};
        run_pulse(0, 5, 0);

        // single-word pulse after three cycles
        mem[0] = {1'b1, 16'hBEEF};
        run_pulse(3, 0, 0);

        // address wrap across the top of memory
        mem[DEPTH-1] = {1'b0, 16'hA001};
        mem[0]       = {1'b0, 16'hA002};
        mem[1]       = {1'b1, 16'hA003};
        run_pulse(1, DEPTH - 1, 0);

        // no marker: forced termination at MAX_LEN, sticky len_err
        for (int i = 0; i < MAX_LEN + 2; i++) mem[100 + i] = {1'b0, SAMPLE_W'(16'h5000 + i)};
        run_pulse(2, 100, 0);

        // abort on the second sample, then a normal pulse
        for (int i = 0; i < 5; i++) mem[200 + i] = {1'(i == 4), SAMPLE_W'(16'h7700 + i)};
        run_pulse(0, 200, 3);
        mem[210] = {1'b0, 16'h1234};
        mem[211] = {1'b1, 16'h5678};
        run_pulse(0, 210, 0);

        // abort while waiting
        run_pulse(4, 210, 2);

        for (int k = 0; k < 10; k++) begin
            d   = int'($urandom_range(0, 5));
            a   = int'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(1, MAX_LEN + 2));
            for (int i = 0; i < len; i++)
                mem[(a + i) % DEPTH] = {1'(i == len - 1), SAMPLE_W'($urandom)};
            run_pulse(d, a, 0);
        end

        // reset during a long wait drops the descriptor and clears len_err
        @(negedge clk);
        drive(1'b1, 100, 300, 1'b0);
        #1;
        check("r6_ready", 32'(bus.desc_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 1'b0);
            #1;
            check("r6_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_len_err = 1'b0;
        check("r6_rst_busy", 32'(bus.busy), 32'd0);
        check("r6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("r6_rst_rd_en", 32'(bus.pmem_rd_en), 32'd0);
        check("r6_rst_last", 32'(bus.out_last), 32'd0);
        check("r6_rst_len_err", 32'(bus.len_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("r6_rel_ready", 32'(bus.desc_ready), 32'd1);
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            #1;
            check("r6_idle_busy", 32'(bus.busy), 32'd0);
            check("r6_idle_valid", 32'(bus.out_valid), 32'd0);
        end
        run_pulse(0, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
